disp_arbiter: RTL and testbench

DISP_ARBITER -- requirements
Module: disp_arbiter

---
 rtl/disp_arbiter_if.sv | 23 ++
 rtl/disp_arbiter.sv | 94 +++++++++
 tb/tb_disp_arbiter.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/disp_arbiter_if.sv
// Requester/display bundle for disp_arbiter.
// slave: arbiter side; master: requesters and display consumer.
interface disp_arbiter_if;
    logic        req0_valid;
    logic [15:0] req0_data;
    logic        req0_ready;
    logic        req1_valid;
    logic [15:0] req1_data;
    logic        req1_ready;
    logic [15:0] disp_value;
    logic [1:0]  disp_owner;
    logic        busy;

    modport slave (
        input  req0_valid, req0_data, req1_valid, req1_data,
        output req0_ready, req1_ready, disp_value, disp_owner, busy
    );

    modport master (
        output req0_valid, req0_data, req1_valid, req1_data,
        input  req0_ready, req1_ready, disp_value, disp_owner, busy
    );
endinterface

// File: rtl/disp_arbiter.sv
// Two-requester round-robin arbiter for a 16-bit seven-segment display with a minimum hold time.
// Define DISP_ARB_PREEMPT_EN to let requester 0 preempt a requester-1 hold.
module disp_arbiter #(
    parameter int unsigned HOLD_CYCLES = 1000
) (
    input  logic           clk,
    input  logic           rst,
    disp_arbiter_if.slave  bus_io
);

    localparam logic [0:0]  StIdle   = 1'b0;
    localparam logic [0:0]  StHold   = 1'b1;
    localparam logic [31:0] HoldLoad = 32'(HOLD_CYCLES - 1);

    logic [0:0]  state_q, state_d;
    logic [31:0] hold_cnt_q, hold_cnt_d;
    logic        last_grant_q, last_grant_d;
    logic [15:0] disp_value_q, disp_value_d;
    logic [1:0]  disp_owner_q, disp_owner_d;
    logic        busy_q, busy_d;
    logic        grant0, grant1;

    // last_grant_q high means requester 1 won last, so requester 0 wins the next tie.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (!rst) begin
            if (state_q == StIdle) begin
                if (bus_io.req0_valid && bus_io.req1_valid) begin
                    grant0 = last_grant_q;
                    grant1 = ~last_grant_q;
                end else begin
                    grant0 = bus_io.req0_valid;
                    grant1 = bus_io.req1_valid;
                end
            end
`ifdef DISP_ARB_PREEMPT_EN
            else if (disp_owner_q == 2'b10) begin
                grant0 = bus_io.req0_valid;
            end
`endif
        end
    end

    always_comb begin
        state_d      = state_q;
        hold_cnt_d   = hold_cnt_q;
        last_grant_d = last_grant_q;
        disp_value_d = disp_value_q;
        disp_owner_d = disp_owner_q;
        busy_d       = busy_q;
        if (grant0 || grant1) begin
            disp_value_d = grant0 ? bus_io.req0_data : bus_io.req1_data;
            disp_owner_d = grant0 ? 2'b01 : 2'b10;
            busy_d       = 1'b1;
            last_grant_d = grant1;
            hold_cnt_d   = HoldLoad;
            state_d      = StHold;
        end else if (state_q == StHold) begin
            if (hold_cnt_q == 32'd0) begin
                state_d      = StIdle;
                busy_d       = 1'b0;
                disp_owner_d = 2'b00;
            end else begin
                hold_cnt_d = hold_cnt_q - 32'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            hold_cnt_q   <= 32'd0;
            last_grant_q <= 1'b1;
            disp_value_q <= 16'h0000;
            disp_owner_q <= 2'b00;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            hold_cnt_q   <= hold_cnt_d;
            last_grant_q <= last_grant_d;
            disp_value_q <= disp_value_d;
            disp_owner_q <= disp_owner_d;
            busy_q       <= busy_d;
        end
    end

    assign bus_io.req0_ready = grant0;
    assign bus_io.req1_ready = grant1;
    assign bus_io.disp_value = disp_value_q;
    assign bus_io.disp_owner = disp_owner_q;
    assign bus_io.busy       = busy_q;

endmodule

// File: tb/tb_disp_arbiter.sv
// Directed self-checking bench for disp_arbiter with HOLD_CYCLES = 4.
module tb_disp_arbiter;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    disp_arbiter_if bus_if ();

    disp_arbiter #(.HOLD_CYCLES(4)) dut (
        .clk    (clk),
        .rst    (rst),
        .bus_io (bus_if)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic check_disp(input string tag, input logic [15:0] v, input logic [1:0] o,
                              input logic b);
        check_eq({tag, "_value"}, 32'(bus_if.disp_value), 32'(v));
        check_eq({tag, "_owner"}, 32'(bus_if.disp_owner), 32'(o));
        check_eq({tag, "_busy"}, 32'(bus_if.busy), 32'(b));
    endtask

    task automatic check_ready(input string tag, input logic r0, input logic r1);
        #1;
        check_eq({tag, "_rdy0"}, 32'(bus_if.req0_ready), 32'(r0));
        check_eq({tag, "_rdy1"}, 32'(bus_if.req1_ready), 32'(r1));
    endtask

    // Walks a hold of 4 cycles starting right after the transfer edge, ending in IDLE.
    task automatic walk_hold(input string tag, input logic [15:0] v, input logic [1:0] o);
        for (int i = 0; i < 4; i++) begin
            check_disp(tag, v, o, 1'b1);
            step();
        end
        check_disp({tag, "_idle"}, v, 2'b00, 1'b0);
    endtask

    logic [15:0] alt_data [2];

    initial begin
        bus_if.req0_valid = 1'b0;
        bus_if.req0_data  = 16'h0000;
        bus_if.req1_valid = 1'b0;
        bus_if.req1_data  = 16'h0000;
        rst = 1'b1;
        step();
        step();
        check_disp("reset", 16'h0000, 2'b00, 1'b0);
        bus_if.req0_valid = 1'b1;
        bus_if.req1_valid = 1'b1;
        check_ready("reset_rdy", 1'b0, 1'b0);

        // Single requester transfer.
        bus_if.req1_valid = 1'b0;
        bus_if.req0_data  = 16'h1234;
        rst = 1'b0;
        check_ready("single", 1'b1, 1'b0);
        step();
        bus_if.req0_valid = 1'b0;
        check_ready("single_hold", 1'b0, 1'b0);
        walk_hold("single", 16'h1234, 2'b01);

        // Round-robin alternation from reset.
        do_reset();
        alt_data[0] = 16'hAAAA;
        alt_data[1] = 16'h5555;
        bus_if.req0_valid = 1'b1;
        bus_if.req0_data  = alt_data[0];
        bus_if.req1_valid = 1'b1;
        bus_if.req1_data  = alt_data[1];
        for (int k = 0; k < 4; k++) begin
            check_ready("rr", (k % 2) == 0, (k % 2) == 1);
            step();
            check_ready("rr_hold", 1'b0, 1'b0);
            for (int i = 0; i < 4; i++) begin
                check_disp("rr", alt_data[k % 2], (k % 2) == 0 ? 2'b01 : 2'b10, 1'b1);
                step();
            end
            check_disp("rr_idle", alt_data[k % 2], 2'b00, 1'b0);
        end
        bus_if.req0_valid = 1'b0;
        bus_if.req1_valid = 1'b0;

        // req0 arrives two cycles into a req1 hold.
        do_reset();
        bus_if.req1_valid = 1'b1;
        bus_if.req1_data  = 16'h0BEE;
        check_ready("pre_r1", 1'b0, 1'b1);
        step();
        bus_if.req1_valid = 1'b0;
        check_disp("pre_h1", 16'h0BEE, 2'b10, 1'b1);
        step();
        bus_if.req0_valid = 1'b1;
        bus_if.req0_data  = 16'h0C0D;
`ifdef DISP_ARB_PREEMPT_EN
        check_ready("pre_take", 1'b1, 1'b0);
        step();
        bus_if.req0_valid = 1'b0;
        walk_hold("pre_new", 16'h0C0D, 2'b01);
`else
        check_ready("pre_block", 1'b0, 1'b0);
        step();
        check_disp("pre_h3", 16'h0BEE, 2'b10, 1'b1);
        step();
        check_disp("pre_h4", 16'h0BEE, 2'b10, 1'b1);
        step();
        check_disp("pre_idle", 16'h0BEE, 2'b00, 1'b0);
        check_ready("pre_late", 1'b1, 1'b0);
        step();
        bus_if.req0_valid = 1'b0;
        walk_hold("pre_new", 16'h0C0D, 2'b01);
`endif

        // Reset in the second hold cycle.
        do_reset();
        bus_if.req0_valid = 1'b1;
        bus_if.req0_data  = 16'h0F0F;
        check_ready("rst_mid_go", 1'b1, 1'b0);
        step();
        bus_if.req0_valid = 1'b0;
        step();
        check_disp("rst_mid_h2", 16'h0F0F, 2'b01, 1'b1);
        rst = 1'b1;
        bus_if.req0_valid = 1'b1;
        bus_if.req0_data  = 16'hAAAA;
        bus_if.req1_valid = 1'b1;
        bus_if.req1_data  = 16'h5555;
        check_ready("rst_mid_rdy", 1'b0, 1'b0);
        step();
        rst = 1'b0;
        check_disp("rst_mid", 16'h0000, 2'b00, 1'b0);
        check_ready("rst_mid_tie", 1'b1, 1'b0);
        step();
        bus_if.req0_valid = 1'b0;
        bus_if.req1_valid = 1'b0;
        walk_hold("rst_mid_next", 16'hAAAA, 2'b01);

        // Data change during hold with valid held.
        bus_if.req0_valid = 1'b1;
        bus_if.req0_data  = 16'h1111;
        check_ready("chg_go", 1'b1, 1'b0);
        step();
        bus_if.req0_data = 16'h2222;
        check_ready("chg_hold", 1'b0, 1'b0);
        walk_hold("chg", 16'h1111, 2'b01);
        check_ready("chg_next", 1'b1, 1'b0);
        step();
        bus_if.req0_valid = 1'b0;
        check_disp("chg_new", 16'h2222, 2'b01, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
